audio_channel_arbiter: RTL and testbench
========================================

AUDIO_CHANNEL_ARBITER -- requirements
Module: audio_channel_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing the single tone channel.
REQ-002 Parameter TICK_CYCLES, default `frequency/(4*`audio_bps), SHALL set clock cycles per note step.
REQ-003 Parameter GAP_TICKS, default 1, SHALL set silent ticks inserted after each completed sequence.
REQ-004 Port clock, input, 1, SHALL be the sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, SHALL be an asynchronous, active-high reset.
REQ-006 Port req, input, N_REQ, SHALL be level requests; bit 0 is highest priority.
REQ-007 Port req_len, input, 8*N_REQ, SHALL give each requester's sequence length in steps; slice i belongs to req[i].
REQ-008 Port cancel, input, 1, SHALL be a user acknowledge that aborts playback.
REQ-009 Port grant, output, N_REQ, SHALL be one-hot or zero, naming the current channel owner.
REQ-010 Port step, output, 8, SHALL be the owner's current note index (its ROM address).
REQ-011 Port step_strobe, output, 1, SHALL pulse one cycle whenever step changes, including the load of 0 at grant.
REQ-012 Port done, output, N_REQ, SHALL pulse one cycle on bit i when requester i's sequence completes normally.
REQ-013 Port busy, output, 1, SHALL be high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, PLAY, GAP and LOCK.
REQ-015 IDLE: if req nonzero, the block SHALL grant the lowest set index next cycle, latch its len, clear step and the tick counter, and enter PLAY.
REQ-016 A latched len of 0 SHALL be treated as 1.
REQ-017 PLAY: the tick counter SHALL count 0..TICK_CYCLES-1; at wrap, step increments and step_strobe pulses.
REQ-018 When the wrap occurs with step == len-1, the block SHALL pulse done[owner], clear grant, and enter GAP; step is not incremented.
REQ-019 Total grant duration for a sequence SHALL be exactly len*TICK_CYCLES cycles.
REQ-020 Preemption: in PLAY, if a req bit with index lower than the owner's is set, the next cycle SHALL regrant to that index, reset step/counter to 0 and pulse step_strobe, with no done for the preempted owner.
REQ-021 Completion SHALL take precedence over preemption in the same cycle.
REQ-022 A req drop by the current owner in PLAY SHALL abort it to GAP with no done.
REQ-023 GAP: grant SHALL be zero for GAP_TICKS*TICK_CYCLES cycles, then return to IDLE. Requests held through the gap are re-arbitrated there; requesters must drop req on done.
REQ-024 cancel SHALL win over all other events: from PLAY or GAP, next cycle grant=0, step=0, no done, enter LOCK.
REQ-025 LOCK SHALL hold until req == 0, then go to IDLE. This suppresses re-grant of requests that were active at cancel.
REQ-026 cancel asserted in IDLE with req == 0 SHALL have no effect; cancel asserted in IDLE with req != 0 SHALL enter LOCK.
REQ-027 The step counter SHALL never exceed len-1. The tick counter width SHALL be $clog2(TICK_CYCLES), with TICK_CYCLES ≥ 2.

Reset
REQ-028 On reset, the block SHALL immediately drive grant=0, step=0, step_strobe=0, done=0, busy=0, counters=0 and state=IDLE.
REQ-029 Reset asserted mid-PLAY SHALL discard the sequence silently, with no done pulse.
REQ-030 After reset deassertion, the first grant SHALL occur no earlier than the second rising edge.

Structure
REQ-031 Package audio_pkg SHALL hold the FSM state enum, the N_REQ default and the default TICK_CYCLES expression.
REQ-032 A sub-module step_tick_divider SHALL provide the clearable tick counter and wrap pulse.
REQ-033 Priority encoding and output registers SHALL live in the top module; all outputs SHALL be registered.

Verification (TICK_CYCLES=4, GAP_TICKS=1, N_REQ=4)
REQ-034 Case: req=0100, len2=3. Required: grant=0100 for 12 cycles, step 0,1,2, three step_strobe pulses, done=0100 once, then 4 cycles with grant=0.
REQ-035 Case: req[3] playing len 8; req[0] asserts at step 2. Required: grant switches to 0001 next cycle, step=0, and no done[3].
REQ-036 Case: req=1010 simultaneously from IDLE. Required: grant=0010. After done[1] and req[1] drops, req[3] is granted after the gap.
REQ-037 Case: cancel mid-PLAY with req still held. Required: grant=0 next cycle, state LOCK, busy=1; after req goes to 0, busy=0 and no grant.
REQ-038 Case: reset pulsed mid-PLAY at step 5. Required: all outputs 0 asynchronously, and no done pulse.
REQ-039 Case: len=0 request. Required: exactly one step (4 cycles), then done.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio channel arbiter: FSM state encoding,
// requester count and the note-step period derived from the system clock rate.
`ifndef FREQUENCY
`define FREQUENCY 50_000_000
`endif
`ifndef AUDIO_BPS
`define AUDIO_BPS 48_000
`endif

package audio_pkg;

  localparam int DEFAULT_N_REQ       = 4;
  localparam int DEFAULT_TICK_CYCLES = `FREQUENCY / (4 * `AUDIO_BPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_LOCK = 2'd3
  } state_t;

  // A zero-length request still plays one note step.
  function automatic logic [7:0] eff_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/step_tick_divider.sv
// Clearable tick counter: counts 0..TICK_CYCLES-1 while enabled and flags the
// last cycle of each tick so the owner can advance exactly on the wrap.
module step_tick_divider #(
  parameter int TICK_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  localparam int W = $clog2(TICK_CYCLES);

  logic [W-1:0] count;

  // Flags the final cycle of the tick; the caller may clear in the same cycle.
  assign wrap = enable && (count == W'(TICK_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/audio_channel_arbiter.sv
// Shares one tone channel between N_REQ requesters: fixed priority (bit 0 wins),
// preemption by higher-priority requests, a silent gap after each sequence and a
// cancel lock that holds until every request has been released.
module audio_channel_arbiter
  import audio_pkg::*;
#(
  parameter int N_REQ       = DEFAULT_N_REQ,
  parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES,
  parameter int GAP_TICKS   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_len,
  input  logic               cancel,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         step,
  output logic               step_strobe,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [1:0]         fsm_state
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t         state;
  logic [OW-1:0]  owner;
  logic [7:0]     len_q;
  logic [15:0]    gap_cnt;
  logic           armed;

  logic [7:0]       len_arr [N_REQ];
  logic [OW-1:0]    low_idx;
  logic [N_REQ-1:0] low_onehot;
  logic             any_req;
  logic             pre_hit;
  logic             owner_req;
  logic             tick_wrap;
  logic             final_step;
  logic             tick_clear;
  logic             tick_enable;

  assign fsm_state = state;
  assign any_req   = |req;
  assign owner_req = req[owner];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      len_arr[i] = req_len[8*i +: 8];
    end
  end

  // Lowest set index; when a preemption is pending this is also the new owner.
  always_comb begin
    low_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) low_idx = OW'(i);
    end
  end

  always_comb begin
    low_onehot = '0;
    low_onehot[low_idx] = 1'b1;
  end

  always_comb begin
    pre_hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (OW'(i) < owner)) pre_hit = 1'b1;
    end
  end

  assign final_step  = tick_wrap && (step == len_q - 8'd1);
  assign tick_enable = (state == ST_PLAY) || (state == ST_GAP);
  // Restart the tick whenever the channel is (re)loaded, aborted or parked.
  assign tick_clear  = (state == ST_IDLE) || (state == ST_LOCK) || cancel ||
                       ((state == ST_PLAY) && (final_step || !owner_req || pre_hit));

  step_tick_divider #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (tick_clear),
    .enable (tick_enable),
    .wrap   (tick_wrap)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= '0;
      step        <= '0;
      step_strobe <= 1'b0;
      done        <= '0;
      busy        <= 1'b0;
      owner       <= '0;
      len_q       <= '0;
      gap_cnt     <= '0;
      armed       <= 1'b0;
    end else begin
      // armed keeps the first post-reset edge from granting.
      armed       <= 1'b1;
      step_strobe <= 1'b0;
      done        <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            if (cancel) begin
              state <= ST_LOCK;
              busy  <= 1'b1;
            end else if (armed) begin
              state       <= ST_PLAY;
              busy        <= 1'b1;
              grant       <= low_onehot;
              owner       <= low_idx;
              len_q       <= eff_len(len_arr[low_idx]);
              step        <= '0;
              step_strobe <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (cancel) begin
            state <= ST_LOCK;
            grant <= '0;
            step  <= '0;
          end else if (final_step) begin
            state   <= ST_GAP;
            done    <= grant;
            grant   <= '0;
            gap_cnt <= '0;
          end else if (!owner_req) begin
            state   <= ST_GAP;
            grant   <= '0;
            gap_cnt <= '0;
          end else if (pre_hit) begin
            grant       <= low_onehot;
            owner       <= low_idx;
            len_q       <= eff_len(len_arr[low_idx]);
            step        <= '0;
            step_strobe <= 1'b1;
          end else if (tick_wrap) begin
            step        <= step + 8'd1;
            step_strobe <= 1'b1;
          end
        end
        ST_GAP: begin
          if (cancel) begin
            state <= ST_LOCK;
            step  <= '0;
          end else if (tick_wrap) begin
            if (gap_cnt == 16'(GAP_TICKS - 1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
        end
        ST_LOCK: begin
          if (!any_req) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_channel_arbiter.sv
// Bench for audio_channel_arbiter: directed scenarios plus random request traffic,
// all compared cycle by cycle against an elapsed-time reference model.
module tb_audio_channel_arbiter;
  import audio_pkg::*;

  localparam int N = 4;
  localparam int T = 4;
  localparam int G = 1;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [8*N-1:0] req_len;
  logic         cancel;
  logic [N-1:0] grant;
  logic [7:0]   step;
  logic         step_strobe;
  logic [N-1:0] done;
  logic         busy;
  logic [1:0]   fsm_state;

  always #5 clock = ~clock;

  audio_channel_arbiter #(
    .N_REQ       (N),
    .TICK_CYCLES (T),
    .GAP_TICKS   (G)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_len     (req_len),
    .cancel      (cancel),
    .grant       (grant),
    .step        (step),
    .step_strobe (step_strobe),
    .done        (done),
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  state_t      m_mode;
  int          m_owner, m_len, m_elapsed, m_gap_left;
  logic [7:0]  m_step;
  logic        m_strobe;
  logic [N-1:0] m_done;
  bit          m_armed;
  logic [N-1:0] exp_q[$];

  function automatic int lowest(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return N;
  endfunction

  task automatic model_reset();
    m_mode = ST_IDLE; m_owner = 0; m_len = 1; m_elapsed = 0; m_gap_left = 0;
    m_step = 0; m_strobe = 0; m_done = 0; m_armed = 0;
  endtask

  task automatic model_start(input int i);
    m_owner   = i;
    m_len     = int'(req_len[8*i +: 8]);
    if (m_len == 0) m_len = 1;
    m_elapsed = 0;
    m_step    = 0;
    m_strobe  = 1;
    m_mode    = ST_PLAY;
  endtask

  // Priority: cancel, then normal completion, then owner release, then preemption.
  task automatic model_step();
    m_strobe = 0;
    m_done   = 0;
    case (m_mode)
      ST_IDLE: if (req != 0) begin
        if (cancel) m_mode = ST_LOCK;
        else if (m_armed) model_start(lowest(req));
      end
      ST_PLAY: begin
        if (cancel) begin
          m_mode = ST_LOCK; m_step = 0;
        end else if (m_elapsed + 1 == m_len * T) begin
          m_done = N'(1) << m_owner;
          exp_q.push_back(m_done);
          m_mode = ST_GAP; m_gap_left = G * T;
        end else if (!req[m_owner]) begin
          m_mode = ST_GAP; m_gap_left = G * T;
        end else if (lowest(req) < m_owner) begin
          model_start(lowest(req));
        end else begin
          m_elapsed++;
          if (m_elapsed % T == 0) m_strobe = 1;
          m_step = 8'(m_elapsed / T);
        end
      end
      ST_GAP: begin
        if (cancel) begin
          m_mode = ST_LOCK; m_step = 0;
        end else begin
          m_gap_left--;
          if (m_gap_left == 0) m_mode = ST_IDLE;
        end
      end
      default: if (req == 0) m_mode = ST_IDLE;
    endcase
    m_armed = 1;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    if (!reset) begin
      check("grant", grant, (m_mode == ST_PLAY) ? (N'(1) << m_owner) : N'(0));
      check("step", step, m_step);
      check("step_strobe", step_strobe, m_strobe);
      check("done", done, m_done);
      check("busy", busy, m_mode != ST_IDLE);
      check("state", fsm_state, m_mode);
      if (done != 0) begin
        if (exp_q.size() == 0) check("done_unexpected", done, 0);
        else check("done_order", done, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_len(input int i, input int len);
    req_len[8*i +: 8] = 8'(len);
  endtask

  task automatic wait_grant(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (grant != 0) break;
      @(negedge clock);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!busy && req == 0) break;
      @(negedge clock);
      if (done != 0) req = req & ~done;
    end
  endtask

  // Plays one owner's sequence to completion, dropping its req on done.
  task automatic play_one(input int idx, output int gcyc, output int strobes,
                          output int dones, output int gapc, output int max_step);
    gcyc = 0; strobes = 0; dones = 0; gapc = 0; max_step = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (grant == (N'(1) << idx)) begin
        gcyc++;
        if (step_strobe) strobes++;
        if (int'(step) > max_step) max_step = int'(step);
      end
      if (fsm_state == ST_GAP) gapc++;
      if (done[idx]) begin dones++; req[idx] = 1'b0; end
      if (dones != 0 && !busy) break;
    end
  endtask

  // ---------------- stimulus ----------------
  int gcyc, strobes, dones, gapc, max_step;
  bit saw_done3;

  initial begin
    reset = 1; req = 0; req_len = 0; cancel = 0;
    repeat (2) @(negedge clock);
    check("reset_grant", grant, 0);
    check("reset_busy", busy, 0);
    check("reset_step", step, 0);

    // single sequence, len 3, request held across reset release
    req = 4'b0100; set_len(2, 3);
    reset = 0;
    @(negedge clock);
    check("first_edge_no_grant", grant, 0);
    play_one(2, gcyc, strobes, dones, gapc, max_step);
    check("len3_grant_cycles", gcyc, 12);
    check("len3_strobes", strobes, 3);
    check("len3_done_count", dones, 1);
    check("len3_gap_cycles", gapc, G * T);
    check("len3_last_step", max_step, 2);
    wait_idle(20);

    // preemption of requester 3 at step 2
    req = 4'b1000; set_len(3, 8);
    saw_done3 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (grant == 4'b1000 && step == 8'd2) break;
    end
    set_len(0, 2); req[0] = 1'b1;
    @(negedge clock);
    check("preempt_grant", grant, 4'b0001);
    check("preempt_step", step, 0);
    for (int k = 0; k < 40; k++) begin
      if (done[3]) saw_done3 = 1;
      if (done[0]) begin req = 0; break; end
      @(negedge clock);
    end
    check("preempt_no_done3", saw_done3, 0);
    wait_idle(20);

    // simultaneous requests 1 and 3
    set_len(1, 2); set_len(3, 1); req = 4'b1010;
    @(negedge clock);
    wait_grant(5);
    check("simul_grant", grant, 4'b0010);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done[1]) begin req[1] = 1'b0; break; end
    end
    @(negedge clock);
    wait_grant(10);
    check("after_gap_grant", grant, 4'b1000);
    wait_idle(20);

    // cancel mid-play with req held
    set_len(0, 5); req = 4'b0001;
    @(negedge clock);
    wait_grant(5);
    repeat (3) @(negedge clock);
    cancel = 1;
    @(negedge clock);
    cancel = 0;
    check("cancel_grant", grant, 0);
    check("cancel_state", fsm_state, ST_LOCK);
    check("cancel_busy", busy, 1);
    repeat (4) @(negedge clock);
    check("lock_hold", fsm_state, ST_LOCK);
    req = 0;
    @(negedge clock);
    check("lock_release_busy", busy, 0);
    check("lock_release_grant", grant, 0);

    // cancel in IDLE without and with requests
    cancel = 1;
    @(negedge clock);
    check("idle_cancel_noreq", fsm_state, ST_IDLE);
    req = 4'b0100;
    @(negedge clock);
    cancel = 0;
    check("idle_cancel_req", fsm_state, ST_LOCK);
    req = 0;
    @(negedge clock);

    // asynchronous reset mid-play at step 5
    set_len(1, 8); req = 4'b0010;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (grant == 4'b0010 && step == 8'd5) break;
    end
    #2 reset = 1;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_step", step, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_strobe", step_strobe, 0);
    req = 0;
    @(negedge clock);
    reset = 0;
    repeat (3) @(negedge clock);

    // zero length plays one step
    set_len(2, 0); req = 4'b0100;
    play_one(2, gcyc, strobes, dones, gapc, max_step);
    check("len0_grant_cycles", gcyc, T);
    check("len0_done_count", dones, 1);
    wait_idle(20);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      cancel = ($urandom_range(0, 80) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (done[i]) req[i] = 1'b0;
          else if ($urandom_range(0, (fsm_state == ST_LOCK) ? 4 : 60) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 12) == 0) begin
          set_len(i, $urandom_range(0, 5));
          req[i] = 1'b1;
        end
      end
    end
    cancel = 0; req = 0;
    repeat (20) @(negedge clock);

    check("pending_done_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
